// File: rtl/ulpi_link.sv
// rtl/ulpi_link.sv - ULPI link controller: PHY reset/power-up, register access engine, RX CMD decode and RX byte stream.
module ulpi_link #(
    parameter int RST_CYCLES     = 64,
    parameter int PWRUP_CYCLES   = 256,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_dir,
    input  logic       i_nxt,
    output logic       o_stp,
    output logic       o_rst,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    input  logic       i_reg_req,
    input  logic       i_reg_we,
    input  logic [5:0] i_reg_addr,
    input  logic [7:0] i_reg_wdata,
    output logic       o_reg_ack,
    output logic [7:0] o_reg_rdata,
    output logic       o_reg_err,
    output logic       o_ready,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_rx_last,
    output logic       o_rx_err,
    output logic [1:0] o_linestate,
    output logic [1:0] o_vbus,
    output logic       o_rxactive
);
    localparam int INIT_MAX = (RST_CYCLES > PWRUP_CYCLES) ? RST_CYCLES : PWRUP_CYCLES;
    localparam int CW = $clog2(INIT_MAX + 1);

    typedef enum logic [3:0] {
        S_RESET, S_WAIT_PHY, S_IDLE, S_WR_CMD, S_WR_DATA, S_WR_STP,
        S_RD_CMD, S_RD_TURN, S_RD_DATA, S_RX_TURN_OUT, S_RX
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   init_cnt_q, init_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            ack_q, ack_d, err_q, err_d;
    logic [7:0]      rdata_q, rdata_d, rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d, rx_last_q, rx_last_d, rx_err_q, rx_err_d;
    logic [1:0]      linestate_q, linestate_d, vbus_q, vbus_d;
    logic            rxactive_q, rxactive_d;
    logic            pkt_open_q, pkt_open_d, err_flag_q, err_flag_d;
    logic            wait_nxt, flag_next;
    logic [7:0]      data_c;
    logic            stp_c;

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        to_cnt_d    = to_cnt_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rx_last_d   = 1'b0;
        rx_err_d    = 1'b0;
        linestate_d = linestate_q;
        vbus_d      = vbus_q;
        rxactive_d  = rxactive_q;
        pkt_open_d  = pkt_open_q;
        err_flag_d  = err_flag_q;
        wait_nxt    = 1'b0;
        flag_next   = err_flag_q;
        data_c      = 8'h00;
        stp_c       = 1'b0;

        case (state_q)
            S_RESET: begin
                if (init_cnt_q == CW'(RST_CYCLES - 1)) begin
                    state_d    = S_WAIT_PHY;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + CW'(1);
                end
            end
            S_WAIT_PHY: begin
                if (init_cnt_q >= CW'(PWRUP_CYCLES)) begin
                    if (!i_dir) state_d = S_IDLE;
                end else begin
                    init_cnt_d = init_cnt_q + CW'(1);
                end
            end
            S_IDLE: begin
                // The IDLE cycle that sees DIR rise is the RX turnaround.
                if (i_dir) begin
                    state_d    = S_RX;
                    pkt_open_d = i_nxt;
                end else if (i_reg_req && !ack_q) begin
                    state_d = i_reg_we ? S_WR_CMD : S_RD_CMD;
                end
            end
            S_WR_CMD, S_WR_DATA, S_RD_CMD: begin
                if (state_q == S_WR_CMD)       data_c = {2'b10, i_reg_addr};
                else if (state_q == S_WR_DATA) data_c = i_reg_wdata;
                else                           data_c = {2'b11, i_reg_addr};
                if (i_dir && !i_nxt) begin
                    state_d    = S_RX;
                    pkt_open_d = 1'b0;
                end else if (i_nxt) begin
                    if (state_q == S_WR_CMD)       state_d = S_WR_DATA;
                    else if (state_q == S_WR_DATA) begin
                        state_d = S_WR_STP;
                        ack_d   = 1'b1;
                    end else                       state_d = S_RD_TURN;
                end else begin
                    wait_nxt = 1'b1;
                end
            end
            S_WR_STP: begin
                stp_c   = !i_dir;
                state_d = S_IDLE;
            end
            S_RD_TURN: begin
                if (i_dir) state_d = S_RD_DATA;
                else       wait_nxt = 1'b1;
            end
            S_RD_DATA: begin
                rdata_d = i_data;
                ack_d   = 1'b1;
                state_d = S_RX_TURN_OUT;
            end
            S_RX_TURN_OUT: begin
                if (!i_dir) state_d = S_IDLE;
            end
            S_RX: begin
                if (i_dir) begin
                    if (i_nxt) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = i_data;
                        pkt_open_d = 1'b1;
                    end else begin
                        linestate_d = i_data[1:0];
                        vbus_d      = i_data[3:2];
                        rxactive_d  = (i_data[5:4] == 2'b01);
                        flag_next   = err_flag_q | (i_data[5:4] == 2'b11);
                        err_flag_d  = flag_next;
                        if (pkt_open_q && i_data[5:4] != 2'b01) begin
                            rx_last_d  = 1'b1;
                            rx_err_d   = flag_next;
                            err_flag_d = 1'b0;
                            pkt_open_d = 1'b0;
                        end
                    end
                end else begin
                    // DIR fell: this cycle is the turnaround back to link-driven.
                    rx_last_d  = pkt_open_q;
                    rx_err_d   = pkt_open_q & err_flag_q;
                    pkt_open_d = 1'b0;
                    err_flag_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_RESET;
        endcase

        if (wait_nxt) begin
            if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                ack_d   = 1'b1;
                err_d   = 1'b1;
                state_d = S_IDLE;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
        if (state_d != state_q) to_cnt_d = '0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_RESET;
            init_cnt_q  <= '0;
            to_cnt_q    <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            rx_last_q   <= 1'b0;
            rx_err_q    <= 1'b0;
            linestate_q <= 2'b00;
            vbus_q      <= 2'b00;
            rxactive_q  <= 1'b0;
            pkt_open_q  <= 1'b0;
            err_flag_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            to_cnt_q    <= to_cnt_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_last_q   <= rx_last_d;
            rx_err_q    <= rx_err_d;
            linestate_q <= linestate_d;
            vbus_q      <= vbus_d;
            rxactive_q  <= rxactive_d;
            pkt_open_q  <= pkt_open_d;
            err_flag_q  <= err_flag_d;
        end
    end

    assign o_rst       = (state_q == S_RESET);
    assign o_ready     = (state_q != S_RESET) && (state_q != S_WAIT_PHY);
    assign o_stp       = stp_c;
    assign o_data      = data_c;
    assign o_reg_ack   = ack_q;
    assign o_reg_err   = err_q;
    assign o_reg_rdata = rdata_q;
    assign o_rx_data   = rx_data_q;
    assign o_rx_valid  = rx_valid_q;
    assign o_rx_last   = rx_last_q;
    assign o_rx_err    = rx_err_q;
    assign o_linestate = linestate_q;
    assign o_vbus      = vbus_q;
    assign o_rxactive  = rxactive_q;
endmodule

// File: tb/tb_ulpi_link.sv
// tb/tb_ulpi_link.sv - Directed and randomized bench for ulpi_link against a behavioural PHY/link model.
module tb_ulpi_link;
    localparam int RST = 64;
    localparam int PWR = 256;
    localparam int TO  = 255;

    logic       clk = 1'b0, rst = 1'b1;
    logic       i_dir = 1'b0, i_nxt = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       req = 1'b0, we = 1'b0;
    logic [5:0] addr = 6'h00;
    logic [7:0] wdata = 8'h00;
    logic       o_stp, o_rst, o_reg_ack, o_reg_err, o_ready;
    logic       o_rx_valid, o_rx_last, o_rx_err, o_rxactive;
    logic [7:0] o_data, o_reg_rdata, o_rx_data;
    logic [1:0] o_linestate, o_vbus;

    ulpi_link #(.RST_CYCLES(RST), .PWRUP_CYCLES(PWR), .TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_dir(i_dir), .i_nxt(i_nxt), .o_stp(o_stp), .o_rst(o_rst),
        .i_data(i_data), .o_data(o_data), .i_reg_req(req), .i_reg_we(we), .i_reg_addr(addr),
        .i_reg_wdata(wdata), .o_reg_ack(o_reg_ack), .o_reg_rdata(o_reg_rdata), .o_reg_err(o_reg_err),
        .o_ready(o_ready), .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid), .o_rx_last(o_rx_last),
        .o_rx_err(o_rx_err), .o_linestate(o_linestate), .o_vbus(o_vbus), .o_rxactive(o_rxactive)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;
    int ack_cnt = 0, stp_cnt = 0, stp_bad = 0, last_cnt = 0;
    logic last_err = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [1:0] exp_ls = 2'b00, exp_vb = 2'b00;
    logic       exp_ra = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (o_rx_valid) got_q.push_back(o_rx_data);
            if (o_rx_last) begin
                last_cnt++;
                last_err = o_rx_err;
            end
            if (o_reg_ack) ack_cnt++;
            if (o_stp) stp_cnt++;
            if (o_stp && i_dir) stp_bad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_data(input logic [7:0] exp, input string tag);
        int i;
        i = 0;
        while (o_data !== exp && i < 40) begin
            tick();
            i++;
        end
        chk(tag, o_data, exp);
    endtask

    task automatic measure_init();
        int rf, rd;
        rf = -1;
        rd = -1;
        rst = 1'b0;
        for (int n = 1; n <= 600 && rd < 0; n++) begin
            tick();
            if (o_rst === 1'b0 && rf < 0) rf = n;
            if (o_ready === 1'b1) rd = n;
        end
        chk("rst_high_cycles", rf, RST);
        chk("ready_cycle", rd, RST + PWR + 1);
    endtask

    // NXT is asserted dly cycles after the link starts driving each byte.
    task automatic do_write(input logic [5:0] a, input logic [7:0] d, input int dly);
        int acks;
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        wait_data({2'b10, a}, "wr_cmd_byte");
        repeat (dly) tick();
        i_nxt = 1'b1; tick(); i_nxt = 1'b0;
        chk("wr_data_byte", o_data, d);
        repeat (dly) tick();
        acks = ack_cnt;
        i_nxt = 1'b1; tick(); i_nxt = 1'b0;
        chk("wr_stp", {o_stp, o_reg_ack, o_reg_err, o_data}, {3'b110, 8'h00});
        req = 1'b0;
        tick();
        chk("wr_one_ack", ack_cnt - acks, 1);
        chk("wr_stp_drop", {o_stp, o_reg_ack}, 2'b00);
    endtask

    task automatic do_read(input logic [5:0] a, input logic [7:0] d, input int dly);
        req = 1'b1; we = 1'b0; addr = a;
        wait_data({2'b11, a}, "rd_cmd_byte");
        repeat (dly) tick();
        i_nxt = 1'b1; tick(); i_nxt = 1'b0;
        i_dir = 1'b1; tick();
        i_data = d; tick();
        chk("rd_ack", {o_reg_ack, o_reg_err, o_reg_rdata}, {2'b10, d});
        req = 1'b0; i_dir = 1'b0; i_data = 8'h00;
        tick();
        chk("rd_idle_noop", {o_data, o_stp}, 9'h000);
    endtask

    // ev: 0 none (close on DIR fall), 1 RxEvent=00, 2 RxEvent=11, 3 RxEvent=01 (stays open).
    task automatic rx_packet(input int nbytes, input int ev, input logic [1:0] ls, input logic [1:0] vb);
        logic [1:0] evb;
        logic       exp_err;
        got_q.delete(); exp_q.delete();
        last_cnt = 0;
        i_dir = 1'b1; i_nxt = 1'b1; tick();
        for (int k = 0; k < nbytes; k++) begin
            i_data = 8'($urandom);
            exp_q.push_back(i_data);
            tick();
        end
        evb = (ev == 1) ? 2'b00 : (ev == 2) ? 2'b11 : 2'b01;
        exp_err = (ev == 2);
        if (ev != 0) begin
            i_nxt = 1'b0; i_data = {2'b00, evb, vb, ls}; tick();
            exp_ls = ls; exp_vb = vb; exp_ra = (evb == 2'b01);
        end
        i_dir = 1'b0; i_nxt = 1'b0; i_data = 8'h00; tick();
        tick();
        chk("rx_byte_count", got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            chk("rx_byte", got_q[k], exp_q[k]);
        chk("rx_last_count", last_cnt, 1);
        chk("rx_err", last_err, exp_err);
        chk("rx_cmd_regs", {o_linestate, o_vbus, o_rxactive}, {exp_ls, exp_vb, exp_ra});
    endtask

    initial begin
        int acks, stps, t0, op;
        repeat (3) tick();
        chk("reset_outputs", {o_rst, o_ready, o_stp, o_reg_ack, o_reg_err, o_rx_valid, o_rx_last, o_data},
            {7'b1000000, 8'h00});
        chk("reset_rx_regs", {o_linestate, o_vbus, o_rxactive, o_reg_rdata}, 13'h0);
        measure_init();

        do_write(6'h0A, 8'h45, 1);
        do_read(6'h16, 8'h5A, 1);

        // Abort in WR_DATA, RX CMD 0x4D, then retry.
        acks = ack_cnt;
        req = 1'b1; we = 1'b1; addr = 6'h0A; wdata = 8'h45;
        wait_data(8'h8A, "ab_cmd");
        i_nxt = 1'b1; tick(); i_nxt = 1'b0;
        chk("ab_data", o_data, 8'h45);
        i_dir = 1'b1; tick();
        i_data = 8'h4D; tick();
        i_dir = 1'b0; i_data = 8'h00; tick();
        chk("ab_rxcmd", {o_linestate, o_vbus, o_rxactive}, 5'b01110);
        chk("ab_no_ack", ack_cnt - acks, 0);
        exp_ls = 2'b01; exp_vb = 2'b11; exp_ra = 1'b0;
        wait_data(8'h8A, "ab_retry_cmd");
        i_nxt = 1'b1; tick(); i_nxt = 1'b0;
        chk("ab_retry_data", o_data, 8'h45);
        i_nxt = 1'b1; tick(); i_nxt = 1'b0;
        chk("ab_retry_ack", {o_stp, o_reg_ack, o_reg_err}, 3'b110);
        req = 1'b0; tick();

        // Directed RX packet: C3 11 22, RX CMD 0x31.
        got_q.delete(); last_cnt = 0;
        i_dir = 1'b1; i_nxt = 1'b1; tick();
        i_data = 8'hC3; tick();
        i_data = 8'h11; tick();
        i_data = 8'h22; tick();
        i_nxt = 1'b0; i_data = 8'h31; tick();
        i_dir = 1'b0; i_data = 8'h00; tick();
        tick();
        chk("rx_dir_bytes", {got_q.size() == 3 ? got_q[0] : 8'hxx, got_q.size() == 3 ? got_q[2] : 8'hxx}, 16'hC322);
        chk("rx_dir_last", {last_cnt[3:0], last_err}, 5'b00011);
        exp_ls = 2'b01; exp_vb = 2'b00; exp_ra = 1'b0;

        // Read timeout: PHY never asserts NXT.
        stps = stp_cnt;
        req = 1'b1; we = 1'b0; addr = 6'h21;
        wait_data(8'hE1, "to_cmd");
        t0 = cyc;
        for (int i = 0; i < 400 && o_reg_ack !== 1'b1; i++) tick();
        chk("to_latency", cyc - t0, TO);
        chk("to_err", {o_reg_ack, o_reg_err}, 2'b11);
        req = 1'b0; tick();
        chk("to_no_stp", stp_cnt - stps, 0);

        // Randomized mix of register accesses and RX packets.
        for (int it = 0; it < 12; it++) begin
            op = $urandom_range(0, 2);
            if (op == 0)      do_write(6'($urandom), 8'($urandom), $urandom_range(0, 3));
            else if (op == 1) do_read(6'($urandom), 8'($urandom), $urandom_range(0, 3));
            else              rx_packet($urandom_range(1, 4), $urandom_range(0, 3),
                                        2'($urandom), 2'($urandom));
        end

        // Reset in the middle of a write: no ack, full init reruns.
        acks = ack_cnt;
        req = 1'b1; we = 1'b1; addr = 6'h05; wdata = 8'h99;
        wait_data(8'h85, "mid_cmd");
        rst = 1'b1; #1;
        chk("mid_rst_out", {o_rst, o_ready, o_data}, {2'b10, 8'h00});
        req = 1'b0;
        tick();
        measure_init();
        chk("mid_no_ack", ack_cnt - acks, 0);
        chk("stp_while_dir", stp_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
